// File: rtl/tonegen_pkg.sv
// Shared types and constants for the tonegen square-wave tone generator.
package tonegen_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_e;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_PENDING = 1;

    function automatic logic [31:0] status_word(input logic busy, input logic pending);
        logic [31:0] w;
        w = 32'd0;
        w[STATUS_BUSY]    = busy;
        w[STATUS_PENDING] = pending;
        return w;
    endfunction

endpackage

// File: rtl/tonegen_prescaler.sv
// Free-running duration tick generator: one-cycle tick every PRESCALE cycles, restartable via clear.
module tonegen_prescaler #(
    parameter int PRESCALE = 6250
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap at LAST, restart from zero on clear.
    always_comb begin
        count_d = count_q;
        tick    = (count_q == LAST);
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (count_q == LAST) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tonegen.sv
// Memory-mapped square-wave tone generator with period/duration/status registers.
// Define TONEGEN_QUEUE_EN to add a one-entry pending-note buffer.
module tonegen
    import tonegen_pkg::*;
#(
    parameter int PERIOD_WIDTH      = 16,
    parameter int DURATION_WIDTH    = 16,
    parameter int DURATION_PRESCALE = 6250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic        period_cs,
    input  logic        duration_cs,
    input  logic        status_cs,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        speaker
);
    localparam int PW = PERIOD_WIDTH;
    localparam int DW = DURATION_WIDTH;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [DW-1:0] duration_q, duration_d;
    logic [PW-1:0] half_q, half_d;
    logic          speaker_q, speaker_d;
    logic          pres_clear_s;
    logic          tick_s;
    logic          expire_s;
    logic          pending_s;
    logic [PW-1:0] act_period_s;
    logic          dur_wr_s;
    logic          dur_nz_s;
    logic [DW-1:0] dur_val_s;
    logic          data_unused_s;

    function automatic logic [PW-1:0] reload(input logic [PW-1:0] p);
        return (p == {PW{1'b0}}) ? {PW{1'b0}} : p - PW'(1);
    endfunction

`ifdef TONEGEN_QUEUE_EN
    logic [PW-1:0] note_period_q, note_period_d;
    logic          pend_q, pend_d;
    logic [PW-1:0] pend_period_q, pend_period_d;
    logic [DW-1:0] pend_duration_q, pend_duration_d;
    assign act_period_s = note_period_q;
    assign pending_s    = pend_q;
`else
    assign act_period_s = period_q;
    assign pending_s    = 1'b0;
`endif

    assign dur_wr_s      = write & duration_cs;
    assign dur_val_s     = data_in[DW-1:0];
    assign dur_nz_s      = (dur_val_s != {DW{1'b0}});
    assign data_unused_s = &{1'b0, data_in};
    assign speaker       = speaker_q;

    tonegen_prescaler #(.PRESCALE(DURATION_PRESCALE)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (pres_clear_s),
        .tick  (tick_s)
    );

    // Note sequencing: tone toggling, duration countdown, start/stop/queue.
    always_comb begin
        state_d      = state_q;
        duration_d   = duration_q;
        half_d       = half_q;
        speaker_d    = speaker_q;
        pres_clear_s = 1'b0;
        expire_s     = 1'b0;
        period_d     = (write && period_cs) ? data_in[PW-1:0] : period_q;
`ifdef TONEGEN_QUEUE_EN
        note_period_d   = note_period_q;
        pend_d          = pend_q;
        pend_period_d   = pend_period_q;
        pend_duration_d = pend_duration_q;
`endif
        case (state_q)
            IDLE: begin
                pres_clear_s = 1'b1;
                if (dur_wr_s && dur_nz_s) begin
                    state_d    = PLAYING;
                    duration_d = dur_val_s;
                    half_d     = reload(period_q);
                    speaker_d  = 1'b0;
`ifdef TONEGEN_QUEUE_EN
                    note_period_d = period_q;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            PLAYING: begin
                if (act_period_s == {PW{1'b0}}) begin
                    speaker_d = 1'b0;
                    half_d    = {PW{1'b0}};
                end else if (half_q == {PW{1'b0}}) begin
                    speaker_d = ~speaker_q;
                    half_d    = reload(act_period_s);
                end else begin
                    half_d = half_q - PW'(1);
                end

                if (tick_s) begin
                    if (duration_q <= DW'(1)) begin
                        expire_s = 1'b1;
`ifdef TONEGEN_QUEUE_EN
                        if (pend_q) begin
                            note_period_d = pend_period_q;
                            duration_d    = pend_duration_q;
                            half_d        = reload(pend_period_q);
                            speaker_d     = 1'b0;
                            pres_clear_s  = 1'b1;
                            pend_d        = 1'b0;
                        end else
`endif
                        begin
                            state_d    = IDLE;
                            speaker_d  = 1'b0;
                            half_d     = {PW{1'b0}};
                            duration_d = {DW{1'b0}};
                        end
                    end else begin
                        duration_d = duration_q - DW'(1);
                    end
                end else begin
                    duration_d = duration_q;
                end

                // A duration write overrides expiry on the same cycle.
                if (dur_wr_s) begin
                    if (!dur_nz_s) begin
                        state_d    = IDLE;
                        speaker_d  = 1'b0;
                        half_d     = {PW{1'b0}};
                        duration_d = {DW{1'b0}};
`ifdef TONEGEN_QUEUE_EN
                        pend_d     = 1'b0;
                    end else if (!expire_s) begin
                        pend_d          = 1'b1;
                        pend_period_d   = period_q;
                        pend_duration_d = dur_val_s;
`endif
                    end else begin
                        state_d      = PLAYING;
                        duration_d   = dur_val_s;
                        half_d       = reload(period_q);
                        speaker_d    = 1'b0;
                        pres_clear_s = 1'b1;
`ifdef TONEGEN_QUEUE_EN
                        note_period_d = period_q;
`endif
                    end
                end else begin
                    state_d = state_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            period_q   <= {PW{1'b0}};
            duration_q <= {DW{1'b0}};
            half_q     <= {PW{1'b0}};
            speaker_q  <= 1'b0;
`ifdef TONEGEN_QUEUE_EN
            note_period_q   <= {PW{1'b0}};
            pend_q          <= 1'b0;
            pend_period_q   <= {PW{1'b0}};
            pend_duration_q <= {DW{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            duration_q <= duration_d;
            half_q     <= half_d;
            speaker_q  <= speaker_d;
`ifdef TONEGEN_QUEUE_EN
            note_period_q   <= note_period_d;
            pend_q          <= pend_d;
            pend_period_q   <= pend_period_d;
            pend_duration_q <= pend_duration_d;
`endif
        end
    end

    // Zero-wait register read mux.
    always_comb begin
        data_out       = 32'd0;
        data_out_valid = read & (period_cs | duration_cs | status_cs);
        if (data_out_valid) begin
            if (period_cs) begin
                data_out[PW-1:0] = period_q;
            end else if (duration_cs) begin
                data_out[DW-1:0] = duration_q;
            end else begin
                data_out = status_word(state_q == PLAYING, pending_s);
            end
        end else begin
            data_out = 32'd0;
        end
    end

endmodule

// File: tb/tb_tonegen.sv
// Directed self-checking bench for tonegen with a 10-cycle duration tick.
module tb_tonegen;
    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic        period_cs;
    logic        duration_cs;
    logic        status_cs;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        speaker;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [2:0] SEL_P = 3'b100;
    localparam logic [2:0] SEL_D = 3'b010;
    localparam logic [2:0] SEL_S = 3'b001;

    always #5 clock = ~clock;

    tonegen #(
        .PERIOD_WIDTH      (16),
        .DURATION_WIDTH    (16),
        .DURATION_PRESCALE (10)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .read           (read),
        .write          (write),
        .period_cs      (period_cs),
        .duration_cs    (duration_cs),
        .status_cs      (status_cs),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .speaker        (speaker)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] val);
        @(negedge clock);
        write = 1'b1;
        {period_cs, duration_cs, status_cs} = sel;
        data_in = val;
        @(posedge clock);
        #1;
        write = 1'b0;
        {period_cs, duration_cs, status_cs} = 3'b000;
        data_in = 32'd0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] d);
        read = 1'b1;
        {period_cs, duration_cs, status_cs} = sel;
        #1;
        d = data_out;
        read = 1'b0;
        {period_cs, duration_cs, status_cs} = 3'b000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_v;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        period_cs = 1'b0; duration_cs = 1'b0; status_cs = 1'b0;
        data_in = 32'd0;
        step(2);
        check("rst_speaker", {31'd0, speaker}, 32'd0);
        check("rst_valid", {31'd0, data_out_valid}, 32'd0);
        rd(SEL_S, d); check("rst_status", d, 32'd0);
        rd(SEL_P, d); check("rst_period", d, 32'd0);
        rd(SEL_D, d); check("rst_duration", d, 32'd0);
        reset = 1'b0;

        // Basic note: period 4, duration 3 ticks = 30 cycles.
        wr(SEL_P, 32'd4);
        rd(SEL_P, d); check("period_rb", d, 32'd4);
        wr(SEL_D, 32'd3);
        rd(SEL_S, d); check("busy_start", d, 32'd1);
        check("spk_start", {31'd0, speaker}, 32'd0);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            exp_v = (k < 30) ? 32'((k / 4) % 2) : 32'd0;
            check("spk_tone", {31'd0, speaker}, exp_v);
            if (k == 10) begin rd(SEL_D, d); check("dur_k10", d, 32'd2); end
            if (k == 29) begin rd(SEL_S, d); check("busy_k29", d, 32'd1); end
            if (k == 30) begin rd(SEL_S, d); check("idle_k30", d, 32'd0); end
        end

        // Status read in IDLE, then valid drops with read low.
        read = 1'b1; status_cs = 1'b1; #1;
        check("idle_data", data_out, 32'd0);
        check("idle_valid", {31'd0, data_out_valid}, 32'd1);
        read = 1'b0; #1;
        check("noread_valid", {31'd0, data_out_valid}, 32'd0);
        status_cs = 1'b0;

        // Rest note: period 0, duration 2.
        wr(SEL_P, 32'd0);
        wr(SEL_D, 32'd2);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("spk_rest", {31'd0, speaker}, 32'd0);
            if (k == 19) begin rd(SEL_S, d); check("rest_busy", d, 32'd1); end
            if (k == 20) begin rd(SEL_S, d); check("rest_idle", d, 32'd0); end
        end

        // Stop mid-note with a zero duration write.
        wr(SEL_P, 32'd4);
        wr(SEL_D, 32'd5);
        step(7);
        check("stop_pre_spk", {31'd0, speaker}, 32'd1);
        wr(SEL_D, 32'd0);
        check("stop_spk", {31'd0, speaker}, 32'd0);
        rd(SEL_S, d); check("stop_status", d, 32'd0);
        rd(SEL_D, d); check("stop_dur", d, 32'd0);

`ifndef TONEGEN_QUEUE_EN
        // Restart mid-note with a new duration.
        wr(SEL_D, 32'd5);
        step(6);
        check("rs_pre_spk", {31'd0, speaker}, 32'd1);
        wr(SEL_D, 32'd2);
        check("rs_spk", {31'd0, speaker}, 32'd0);
        rd(SEL_D, d); check("rs_dur", d, 32'd2);
        rd(SEL_S, d); check("rs_busy", d, 32'd1);
        step(3);
        check("rs_spk3", {31'd0, speaker}, 32'd0);
        step(1);
        check("rs_spk4", {31'd0, speaker}, 32'd1);
        wr(SEL_D, 32'd0);
`endif

        // Duration write on the expiry edge starts a new note.
        wr(SEL_D, 32'd1);
        step(9);
        wr(SEL_D, 32'd1);
        rd(SEL_S, d); check("sim_busy", d, 32'd1);
        rd(SEL_D, d); check("sim_dur", d, 32'd1);
        step(9);
        rd(SEL_S, d); check("sim_busy9", d, 32'd1);
        step(1);
        rd(SEL_S, d); check("sim_idle", d, 32'd0);

        // Reset mid-note.
        wr(SEL_P, 32'd3);
        wr(SEL_D, 32'd9);
        step(5);
        check("rm_pre_spk", {31'd0, speaker}, 32'd1);
        rd(SEL_D, d); check("rm_pre_dur", d, 32'd9);
        @(negedge clock);
        reset = 1'b1;
        step(1);
        check("rm_spk", {31'd0, speaker}, 32'd0);
        rd(SEL_S, d); check("rm_status", d, 32'd0);
        rd(SEL_D, d); check("rm_dur", d, 32'd0);
        rd(SEL_P, d); check("rm_period", d, 32'd0);
        reset = 1'b0;

`ifdef TONEGEN_QUEUE_EN
        // Queued note: period 4 x 2 ticks, then period 6 x 1 tick.
        wr(SEL_P, 32'd4);
        wr(SEL_D, 32'd2);
        step(3);
        wr(SEL_P, 32'd6);
        wr(SEL_D, 32'd1);
        rd(SEL_S, d); check("q_status3", d, 32'd3);
        for (int k = 6; k <= 30; k++) begin
            step(1);
            if (k == 12) check("q_spk12", {31'd0, speaker}, 32'd1);
            if (k == 20) begin
                check("q_spk20", {31'd0, speaker}, 32'd0);
                rd(SEL_S, d); check("q_status1", d, 32'd1);
                rd(SEL_D, d); check("q_dur20", d, 32'd1);
            end
            if (k == 25) check("q_spk25", {31'd0, speaker}, 32'd0);
            if (k == 26) check("q_spk26", {31'd0, speaker}, 32'd1);
            if (k == 29) begin rd(SEL_S, d); check("q_busy29", d, 32'd1); end
            if (k == 30) begin rd(SEL_S, d); check("q_idle30", d, 32'd0); end
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
